// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, bit-mixing functions and core FSM state type.
package sha256_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRounds,
    StFinal
  } state_e;

  // Working variables; a sits in the most significant word.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] f;
    logic [31:0] g;
    logic [31:0] h;
  } work_t;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // IV[0] is H0.
  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_multiround_core_if.sv
// Start/abort handshake and digest return path between padder, core and collector.
interface sha256_multiround_core_if;
  logic         init;
  logic         next;
  logic         use_ext_state;
  logic [255:0] init_state;
  logic [511:0] block;
  logic         abort;
  logic         ready;
  logic [255:0] digest;
  logic         digest_valid;

  modport master (
    output init, next, use_ext_state, init_state, block, abort,
    input  ready, digest, digest_valid
  );

  modport slave (
    input  init, next, use_ext_state, init_state, block, abort,
    output ready, digest, digest_valid
  );
endinterface

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round.
module sha256_round
  import sha256_pkg::*;
(
  input  work_t       work_i,
  input  logic [31:0] k_i,
  input  logic [31:0] w_i,
  output work_t       work_o
);

  logic [31:0] t1;
  logic [31:0] t2;

  always_comb begin
    t1 = work_i.h + big_sigma1(work_i.e) + ch(work_i.e, work_i.f, work_i.g) + k_i + w_i;
    t2 = big_sigma0(work_i.a) + maj(work_i.a, work_i.b, work_i.c);
    work_o = '{
      a: t1 + t2,
      b: work_i.a,
      c: work_i.b,
      d: work_i.c,
      e: work_i.d + t1,
      f: work_i.e,
      g: work_i.f,
      h: work_i.g
    };
  end

endmodule

// File: rtl/sha256_multiround_core.sv
// SHA-256 block compression retiring ROUNDS_PER_CYCLE rounds per clock, with chaining
// from IV, external state or the previous digest.
module sha256_multiround_core
  import sha256_pkg::*;
#(
  parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
  input logic                     clk,
  input logic                     reset,
  sha256_multiround_core_if.slave core_if
);

  localparam int unsigned R = ROUNDS_PER_CYCLE;

  if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_rounds
    $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  state_e       state_q, state_d;
  logic [6:0]   round_q, round_d;
  logic [31:0]  h_q [8];
  logic [31:0]  h_d [8];
  work_t        work_q, work_d;
  logic [31:0]  w_q [16];
  logic [31:0]  w_d [16];
  logic [255:0] digest_q, digest_d;
  logic         digest_valid_q, digest_valid_d;
  logic         chain_ok_q, chain_ok_d;

  work_t             stage [R+1];
  logic [31:0]       w_ext [16+R];
  logic [31:0]       chain_h [8];
  logic [7:0][31:0]  work_words;
  logic              start;

  assign stage[0]   = work_q;
  assign work_words = work_q;

  // Window extended by R freshly scheduled words; W[t+i] sits at index i.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      w_ext[i] = w_q[i];
    end
    for (int k = 0; k < int'(R); k++) begin
      w_ext[16+k] = small_sigma1(w_ext[14+k]) + w_ext[9+k] + small_sigma0(w_ext[1+k]) + w_ext[k];
    end
  end

  for (genvar i = 0; i < R; i++) begin : g_round
    logic [5:0] k_idx;
    assign k_idx = round_q[5:0] + 6'(i);

    sha256_round u_round (
      .work_i (stage[i]),
      .k_i    (K[k_idx]),
      .w_i    (w_q[i]),
      .work_o (stage[i+1])
    );
  end

  always_comb begin
    state_d        = state_q;
    round_d        = round_q;
    h_d            = h_q;
    work_d         = work_q;
    w_d            = w_q;
    digest_d       = digest_q;
    digest_valid_d = digest_valid_q;
    chain_ok_d     = chain_ok_q;
    chain_h        = h_q;
    start          = 1'b0;

    case (state_q)
      StIdle: begin
        if (core_if.init) begin
          start = 1'b1;
          for (int i = 0; i < 8; i++) begin
            chain_h[i] = core_if.use_ext_state ? core_if.init_state[32*i +: 32] : IV[i];
          end
        end else if (core_if.next && chain_ok_q) begin
          start = 1'b1;
        end
        if (start) begin
          h_d    = chain_h;
          work_d = work_t'({chain_h[0], chain_h[1], chain_h[2], chain_h[3],
                            chain_h[4], chain_h[5], chain_h[6], chain_h[7]});
          for (int j = 0; j < 16; j++) begin
            w_d[j] = core_if.block[511-32*j -: 32];
          end
          round_d        = '0;
          digest_valid_d = 1'b0;
          state_d        = StRounds;
        end
      end

      StRounds: begin
        if (core_if.abort) begin
          digest_valid_d = 1'b0;
          chain_ok_d     = 1'b0;
          state_d        = StIdle;
        end else begin
          work_d = stage[R];
          for (int j = 0; j < 16; j++) begin
            w_d[j] = w_ext[j+int'(R)];
          end
          round_d = round_q + 7'(R);
          if (round_d == 7'd64) begin
            state_d = StFinal;
          end
        end
      end

      StFinal: begin
        if (core_if.abort) begin
          digest_valid_d = 1'b0;
          chain_ok_d     = 1'b0;
          state_d        = StIdle;
        end else begin
          for (int i = 0; i < 8; i++) begin
            h_d[i]                    = h_q[i] + work_words[7-i];
            digest_d[255-32*i -: 32] = h_q[i] + work_words[7-i];
          end
          digest_valid_d = 1'b1;
          chain_ok_d     = 1'b1;
          state_d        = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      round_q        <= '0;
      work_q         <= '0;
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
      chain_ok_q     <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        h_q[i] <= '0;
      end
      for (int j = 0; j < 16; j++) begin
        w_q[j] <= '0;
      end
    end else begin
      state_q        <= state_d;
      round_q        <= round_d;
      work_q         <= work_d;
      digest_q       <= digest_d;
      digest_valid_q <= digest_valid_d;
      chain_ok_q     <= chain_ok_d;
      h_q            <= h_d;
      w_q            <= w_d;
    end
  end

  assign core_if.ready        = (state_q == StIdle);
  assign core_if.digest       = digest_q;
  assign core_if.digest_valid = digest_valid_q;

endmodule

// File: tb/tb_sha256_multiround_core.sv
// Directed bench: known SHA-256 vectors, latency per unroll factor, abort, busy starts, reset.
module tb_sha256_multiround_core;

  localparam logic [511:0] BlkAbc = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BlkTwo1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] BlkTwo2 = {448'h0, 64'h1c0};
  localparam logic [255:0] DigAbc =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DigTwo1 =
    256'h85e655d6417a17953363376a624cde5c76e09589cac5f811cc4b32c1f20e533a;
  localparam logic [255:0] DigTwo2 =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] IvRev = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  logic clk;
  logic reset;
  int   passed;
  int   failed;
  int   total;
  int   cnt;
  int   c1, c4, c8;

  sha256_multiround_core_if bus1 ();
  sha256_multiround_core_if bus4 ();
  sha256_multiround_core_if bus8 ();

  sha256_multiround_core #(.ROUNDS_PER_CYCLE(1)) u_dut1 (
    .clk     (clk),
    .reset   (reset),
    .core_if (bus1)
  );
  sha256_multiround_core #(.ROUNDS_PER_CYCLE(4)) u_dut4 (
    .clk     (clk),
    .reset   (reset),
    .core_if (bus4)
  );
  sha256_multiround_core #(.ROUNDS_PER_CYCLE(8)) u_dut8 (
    .clk     (clk),
    .reset   (reset),
    .core_if (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Holds a start request on bus1 across exactly one rising edge.
  task automatic pulse(input logic ini, input logic nxt, input logic ext,
                       input logic [255:0] st, input logic [511:0] blk);
    @(negedge clk);
    bus1.init          = ini;
    bus1.next          = nxt;
    bus1.use_ext_state = ext;
    bus1.init_state    = st;
    bus1.block         = blk;
    @(negedge clk);
    bus1.init = 1'b0;
    bus1.next = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (bus1.ready !== 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    passed = 0;
    failed = 0;
    total  = 0;
    reset  = 1'b1;
    {bus1.init, bus1.next, bus1.use_ext_state, bus1.abort} = '0;
    {bus4.init, bus4.next, bus4.use_ext_state, bus4.abort} = '0;
    {bus8.init, bus8.next, bus8.use_ext_state, bus8.abort} = '0;
    bus1.init_state = '0; bus4.init_state = '0; bus8.init_state = '0;
    bus1.block      = '0; bus4.block      = '0; bus8.block      = '0;

    #3;
    check("rst_ready", bus1.ready, 1);
    check("rst_valid", bus1.digest_valid, 0);
    check("rst_digest", bus1.digest, 256'h0);
    check("rst_ready_r8", bus8.ready, 1);
    @(negedge clk);
    reset = 1'b0;

    // "abc" on all three unroll factors at once
    @(negedge clk);
    bus1.init = 1'b1; bus4.init = 1'b1; bus8.init = 1'b1;
    bus1.block = BlkAbc; bus4.block = BlkAbc; bus8.block = BlkAbc;
    @(negedge clk);
    bus1.init = 1'b0; bus4.init = 1'b0; bus8.init = 1'b0;
    c1 = 0; c4 = 0; c8 = 0;
    for (int n = 0; n < 80; n++) begin
      if (bus1.ready !== 1'b1) c1++;
      if (bus4.ready !== 1'b1) c4++;
      if (bus8.ready !== 1'b1) c8++;
      @(negedge clk);
    end
    check("abc_lat_r1", c1, 65);
    check("abc_lat_r4", c4, 17);
    check("abc_lat_r8", c8, 9);
    check("abc_dig_r1", bus1.digest, DigAbc);
    check("abc_dig_r4", bus4.digest, DigAbc);
    check("abc_dig_r8", bus8.digest, DigAbc);
    check("abc_valid_r1", bus1.digest_valid, 1);
    check("abc_valid_r8", bus8.digest_valid, 1);

    // Two-block message: init then next
    pulse(1'b1, 1'b0, 1'b0, '0, BlkTwo1);
    check("two1_valid_drop", bus1.digest_valid, 0);
    check("two1_dig_hold", bus1.digest, DigAbc);
    wait_ready(cnt);
    check("two1_lat", cnt, 65);
    check("two1_dig", bus1.digest, DigTwo1);
    pulse(1'b0, 1'b1, 1'b0, '0, BlkTwo2);
    check("two2_busy", bus1.ready, 0);
    check("two2_dig_hold", bus1.digest, DigTwo1);
    wait_ready(cnt);
    check("two2_lat", cnt, 65);
    check("two2_dig", bus1.digest, DigTwo2);
    check("two2_valid", bus1.digest_valid, 1);

    // External chaining state equal to the IV
    pulse(1'b1, 1'b0, 1'b1, IvRev, BlkAbc);
    wait_ready(cnt);
    check("ext_dig", bus1.digest, DigAbc);

    // init while busy is ignored and the running hash completes unchanged
    pulse(1'b1, 1'b0, 1'b0, '0, BlkAbc);
    repeat (9) @(negedge clk);
    pulse(1'b1, 1'b0, 1'b1, IvRev, BlkTwo1);
    wait_ready(cnt);
    check("busy_lat", cnt, 54);
    check("busy_dig", bus1.digest, DigAbc);

    // Abort mid-run, with an ignored init at cycle 10
    pulse(1'b1, 1'b0, 1'b0, '0, BlkTwo1);
    repeat (8) @(negedge clk);
    bus1.init = 1'b1;
    @(negedge clk);
    bus1.init = 1'b0;
    check("abort_busy10", bus1.ready, 0);
    repeat (9) @(negedge clk);
    bus1.abort = 1'b1;
    @(negedge clk);
    bus1.abort = 1'b0;
    check("abort_ready", bus1.ready, 1);
    check("abort_valid", bus1.digest_valid, 0);
    check("abort_dig_hold", bus1.digest, DigAbc);
    pulse(1'b0, 1'b1, 1'b0, '0, BlkAbc);
    check("abort_next_ign", bus1.ready, 1);
    repeat (3) @(negedge clk);
    check("abort_next_ign3", bus1.ready, 1);
    pulse(1'b1, 1'b0, 1'b0, '0, BlkAbc);
    wait_ready(cnt);
    check("abort_re_lat", cnt, 65);
    check("abort_re_dig", bus1.digest, DigAbc);
    check("abort_re_valid", bus1.digest_valid, 1);

    // abort while idle changes nothing
    @(negedge clk);
    bus1.abort = 1'b1;
    @(negedge clk);
    bus1.abort = 1'b0;
    check("idle_abort_valid", bus1.digest_valid, 1);
    check("idle_abort_ready", bus1.ready, 1);

    // Asynchronous reset at round 30
    pulse(1'b1, 1'b0, 1'b0, '0, BlkTwo1);
    repeat (29) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_ready", bus1.ready, 1);
    check("mid_rst_valid", bus1.digest_valid, 0);
    check("mid_rst_digest", bus1.digest, 256'h0);
    @(negedge clk);
    reset = 1'b0;
    pulse(1'b0, 1'b1, 1'b0, '0, BlkAbc);
    check("rst_next_ign", bus1.ready, 1);
    pulse(1'b1, 1'b0, 1'b0, '0, BlkAbc);
    wait_ready(cnt);
    check("rst_re_lat", cnt, 65);
    check("rst_re_dig", bus1.digest, DigAbc);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
